// File: rtl/zknde32_iter_pkg.sv
// Shared types and GF(2^8) helpers for the iterative AES32 unit.
// The S-box and its inverse are evaluated as field inversion plus the AES affine map.
package zknde32_iter_pkg;

  typedef enum logic [1:0] {
    AES_ES  = 2'd0,
    AES_ESM = 2'd1,
    AES_DS  = 2'd2,
    AES_DSM = 2'd3
  } aes_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Reduction constant for x^8 + x^4 + x^3 + x + 1.
  localparam logic [7:0] GF_POLY     = 8'h1B;
  localparam logic [7:0] SBOX_CONST  = 8'h63;
  localparam logic [7:0] ISBOX_CONST = 8'h05;

  localparam logic [7:0] MC_2  = 8'h02;
  localparam logic [7:0] MC_3  = 8'h03;
  localparam logic [7:0] IMC_9 = 8'h09;
  localparam logic [7:0] IMC_B = 8'h0B;
  localparam logic [7:0] IMC_D = 8'h0D;
  localparam logic [7:0] IMC_E = 8'h0E;

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? GF_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8); zero maps to zero.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < 6; i++) r = gf_mul(gf_mul(r, r), x);
    return gf_mul(r, r);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] i;
    i = gf_inv(x);
    return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ SBOX_CONST;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] y);
    return gf_inv(rotl8(y, 1) ^ rotl8(y, 3) ^ rotl8(y, 6) ^ ISBOX_CONST);
  endfunction

  function automatic logic [31:0] rotl_bytes(input logic [31:0] w, input logic [1:0] n);
    logic [31:0] r;
    unique case (n)
      2'd0: r = w;
      2'd1: r = {w[23:0], w[31:24]};
      2'd2: r = {w[15:0], w[31:16]};
      2'd3: r = {w[7:0],  w[31:8]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/zknde32_iter_aes_byte_lane.sv
// One S-box lane: substitutes a source byte, optionally mixes it into a column word,
// and rotates the word into the byte position it came from.
module aes_byte_lane
  import zknde32_iter_pkg::*;
#(
  parameter bit ENC_EN = 1'b1,
  parameter bit DEC_EN = 1'b1
) (
  input  logic [7:0]  x,
  input  aes_op_t     op,
  input  logic [1:0]  bs,
  input  logic        en,
  output logic [31:0] term
);

  logic [7:0]  s;
  logic [7:0]  si;
  logic [31:0] word;

  // A disabled direction contributes a zero term, so the result degenerates to A.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    s    = sbox(x);
    si   = inv_sbox(x);
    word = '0;
    if (en) begin
      unique case (op)
        AES_ES:  if (ENC_EN) word = {24'h0, s};
        AES_ESM: if (ENC_EN) word = {gf_mul(s, MC_3), s, s, gf_mul(s, MC_2)};
        AES_DS:  if (DEC_EN) word = {24'h0, si};
        AES_DSM: if (DEC_EN) word = {gf_mul(si, IMC_B), gf_mul(si, IMC_D),
                                     gf_mul(si, IMC_9), gf_mul(si, IMC_E)};
      endcase
    end
    term = rotl_bytes(word, bs);
  end

endmodule

// File: rtl/zknde32_iter.sv
// Multi-cycle AES32 functional unit with valid/ready handshakes and flush.
// Column mode folds the four aes32 byte ops on one rs2 word into a single request.
module zknde32_iter
  import zknde32_iter_pkg::*;
#(
  parameter int NSBOX  = 4,
  parameter bit ENC_EN = 1'b1,
  parameter bit DEC_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic        in_column,
  input  logic [1:0]  in_bs,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result
);

  localparam int ITERS = 4 / NSBOX;

  if (!(NSBOX == 1 || NSBOX == 2 || NSBOX == 4)) begin : g_bad_nsbox
    $error("zknde32_iter: NSBOX must be 1, 2 or 4");
  end
  if (!(ENC_EN || DEC_EN)) begin : g_bad_paths
    $error("zknde32_iter: at least one of ENC_EN/DEC_EN must be set");
  end

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] b_q, b_d;
  aes_op_t     op_q, op_d;
  logic        column_q, column_d;
  logic [1:0]  bs_q, bs_d;
  logic [1:0]  cnt_q, cnt_d;

  logic [7:0]  lane_x    [NSBOX];
  logic [1:0]  lane_bs   [NSBOX];
  logic        lane_en   [NSBOX];
  logic [31:0] lane_term [NSBOX];
  logic [31:0] terms;
  logic        last_iter;
  logic        accept;

  // Column mode walks the bytes NSBOX at a time; single mode uses lane 0 only.
  always_comb begin
    for (int i = 0; i < NSBOX; i++) begin
      lane_bs[i] = column_q ? 2'(int'(cnt_q) * NSBOX + i) : bs_q;
      lane_en[i] = column_q || (i == 0);
      lane_x[i]  = b_q[{lane_bs[i], 3'b000} +: 8];
    end
  end

  for (genvar g = 0; g < NSBOX; g++) begin : g_lane
    aes_byte_lane #(
      .ENC_EN (ENC_EN),
      .DEC_EN (DEC_EN)
    ) u_lane (
      .x    (lane_x[g]),
      .op   (op_q),
      .bs   (lane_bs[g]),
      .en   (lane_en[g]),
      .term (lane_term[g])
    );
  end

  always_comb begin
    terms = '0;
    for (int i = 0; i < NSBOX; i++) terms = terms ^ lane_term[i];
  end

  assign in_ready   = reset_n && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
  assign accept     = in_valid && in_ready;
  assign last_iter  = !column_q || (cnt_q == 2'(ITERS - 1));
  assign out_valid  = (state_q == ST_DONE);
  assign out_result = out_valid ? acc_q : '0;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    b_d      = b_q;
    op_d     = op_q;
    column_d = column_q;
    bs_d     = bs_q;
    cnt_d    = cnt_q;

    // Flush overrides both a completing handshake and a same-cycle accept.
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        ST_BUSY: begin
          acc_d = acc_q ^ terms;
          cnt_d = cnt_q + 2'd1;
          if (last_iter) state_d = ST_DONE;
        end
        ST_DONE: if (out_ready) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase

      if (accept) begin
        state_d  = ST_BUSY;
        acc_d    = in_a;
        b_d      = in_b;
        op_d     = aes_op_t'(in_op);
        column_d = in_column;
        bs_d     = in_bs;
        cnt_d    = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      b_q      <= '0;
      op_q     <= AES_ES;
      column_q <= 1'b0;
      bs_q     <= '0;
      cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking so every flop updates from the values seen before the edge.
      state_q  <= state_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      op_q     <= op_d;
      column_q <= column_d;
      bs_q     <= bs_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_zknde32_iter.sv
// Bench for zknde32_iter: three instances (NSBOX = 1, 2, 4) share data inputs and are
// checked against a table-driven AES32 model built from the field arithmetic.
module tb_zknde32_iter;
  import zknde32_iter_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic [2:0]  in_valid;
  logic [2:0]  in_ready;
  logic [1:0]  in_op;
  logic        in_column;
  logic [1:0]  in_bs;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  out_valid;
  logic [2:0]  out_ready;
  logic [31:0] out_result [3];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [7:0] sbox_t  [256];
  logic [7:0] isbox_t [256];

  // Instance k has NSBOX = 1 << k.
  for (genvar k = 0; k < 3; k++) begin : g_dut
    zknde32_iter #(.NSBOX(1 << k)) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (flush),
      .in_valid   (in_valid[k]),
      .in_ready   (in_ready[k]),
      .in_op      (in_op),
      .in_column  (in_column),
      .in_bs      (in_bs),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid[k]),
      .out_ready  (out_ready[k]),
      .out_result (out_result[k])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Carry-less product followed by polynomial reduction.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] ref_rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // Walk generator 3 and its inverse together to fill the S-box.
  task automatic build_tables();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int it = 0; it < 255; it++) begin
      p = p ^ (p << 1) ^ (p[7] ? 8'h1B : 8'h00);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ ref_rotl8(q, 1) ^ ref_rotl8(q, 2) ^ ref_rotl8(q, 3) ^ ref_rotl8(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end
    sbox_t[0] = 8'h63;
    for (int i = 0; i < 256; i++) isbox_t[sbox_t[i]] = 8'(i);
  endtask

  function automatic logic [31:0] ref_aes32(input logic [1:0] op, input int bs,
                                            input logic [31:0] a, input logic [31:0] b);
    logic [7:0]  x, s;
    logic [31:0] w;
    int          sh;
    x = 8'(b >> (8 * bs));
    case (op)
      2'd0: w = {24'h0, sbox_t[x]};
      2'd1: begin
        s = sbox_t[x];
        w = {ref_mul(s, 8'h03), s, s, ref_mul(s, 8'h02)};
      end
      2'd2: w = {24'h0, isbox_t[x]};
      default: begin
        s = isbox_t[x];
        w = {ref_mul(s, 8'h0B), ref_mul(s, 8'h0D), ref_mul(s, 8'h09), ref_mul(s, 8'h0E)};
      end
    endcase
    sh = 8 * bs;
    w  = (w << sh) | (w >> (32 - sh));
    return a ^ w;
  endfunction

  function automatic logic [31:0] ref_req(input logic [1:0] op, input logic col, input logic [1:0] bs,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    if (!col) return ref_aes32(op, int'(bs), a, b);
    r = a;
    for (int j = 0; j < 4; j++) r = ref_aes32(op, j, r, b);
    return r;
  endfunction

  function automatic int exp_lat(input int k, input logic col);
    return col ? (4 >> k) : 1;
  endfunction

  // Present a request at a negedge, wait (bounded) for acceptance, then scramble the inputs.
  task automatic issue(input int k, input logic [1:0] op, input logic col, input logic [1:0] bs,
                       input logic [31:0] a, input logic [31:0] b);
    int waited;
    waited = 0;
    @(negedge clk);
    in_op = op; in_column = col; in_bs = bs; in_a = a; in_b = b;
    in_valid[k] = 1'b1;
    while (!in_ready[k] && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("accept_ready", 32'(in_ready[k]), 32'd1);
    @(posedge clk);
    #1;
    in_valid[k] = 1'b0;
    in_a = $urandom; in_b = $urandom;
    in_op = 2'($urandom); in_column = 1'($urandom); in_bs = 2'($urandom);
  endtask

  // Called 1 time unit after the accepting edge; counts edges until out_valid.
  task automatic collect(input int k, input string tag, input logic [31:0] exp, input int lat);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid[k]) seen = 1'b1;
    end
    check({tag, "_lat"}, 32'(n), 32'(lat));
    check({tag, "_res"}, out_result[k], exp);
  endtask

  task automatic watch_idle(input int k, input int cycles, input string tag);
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #1;
      if (out_valid[k]) seen = 1'b1;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    logic [1:0]  r_op, r_bs;
    logic        r_col;
    logic [31:0] r_a, r_b, r_exp;
    int          r_k;

    build_tables();
    reset_n = 1'b1; flush = 1'b0; in_valid = '0; out_ready = 3'b111;
    in_op = '0; in_column = 1'b0; in_bs = '0; in_a = '0; in_b = '0;
    #1 reset_n = 1'b0;
    #2;
    for (int k = 0; k < 3; k++) begin
      check("rst_in_ready",   32'(in_ready[k]),  32'd0);
      check("rst_out_valid",  32'(out_valid[k]), 32'd0);
      check("rst_out_result", out_result[k],     32'h0);
    end
    #20;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check("idle_in_ready", 32'(in_ready[k]), 32'd1);

    // Directed vectors on every lane count.
    for (int k = 0; k < 3; k++) begin
      issue(k, AES_ESM, 1'b0, 2'd0, 32'h0, 32'h0);
      collect(k, "esm_bs0", 32'hA56363C6, 1);
      issue(k, AES_ESM, 1'b0, 2'd1, 32'h0, 32'h0);
      collect(k, "esm_bs1", 32'h6363C6A5, 1);
      issue(k, AES_ES, 1'b0, 2'd0, 32'hFFFFFFFF, 32'h0);
      collect(k, "es_ones", 32'hFFFFFF9C, 1);
      issue(k, AES_DS, 1'b0, 2'd0, 32'h0, 32'h0);
      collect(k, "ds_zero", 32'h00000052, 1);
      issue(k, AES_ESM, 1'b1, 2'd0, 32'h0, 32'h0);
      collect(k, "col_esm", 32'h63636363, exp_lat(k, 1'b1));
      issue(k, AES_DSM, 1'b1, 2'd0, 32'h0, 32'h0);
      collect(k, "col_dsm", 32'h52525252, exp_lat(k, 1'b1));
    end

    // Backpressure then back-to-back accept on NSBOX=2.
    out_ready[1] = 1'b0;
    issue(1, AES_ESM, 1'b1, 2'd0, 32'h0, 32'h0);
    collect(1, "bp", 32'h63636363, 2);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check("bp_valid",  32'(out_valid[1]), 32'd1);
      check("bp_result", out_result[1],     32'h63636363);
      check("bp_ready",  32'(in_ready[1]),  32'd0);
    end
    @(negedge clk);
    in_op = AES_DS; in_column = 1'b0; in_bs = 2'd0; in_a = 32'h12345678; in_b = 32'h0;
    in_valid[1] = 1'b1;
    out_ready[1] = 1'b1;
    #1;
    check("b2b_ready", 32'(in_ready[1]), 32'd1);
    @(posedge clk);
    #1;
    in_valid[1] = 1'b0;
    check("b2b_busy", 32'(out_valid[1]), 32'd0);
    collect(1, "b2b", 32'h1234562A, 1);

    // Flush mid-BUSY on NSBOX=1 column.
    issue(0, AES_ESM, 1'b1, 2'd0, 32'h0, 32'h0);
    @(negedge clk) flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy_ready", 32'(in_ready[0]), 32'd1);
    watch_idle(0, 8, "flush_busy_quiet");
    issue(0, AES_DSM, 1'b1, 2'd0, 32'h0, 32'h0);
    collect(0, "after_flush", 32'h52525252, 4);

    // Request presented together with flush is dropped.
    @(negedge clk);
    flush = 1'b1;
    in_op = AES_ES; in_column = 1'b0; in_bs = 2'd0; in_a = 32'h0; in_b = 32'h0;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid[0] = 1'b0;
    watch_idle(0, 6, "flush_drop_quiet");

    // Flush beats a completing handshake in DONE.
    out_ready[0] = 1'b0;
    issue(0, AES_ES, 1'b0, 2'd0, 32'h0, 32'h0);
    collect(0, "done_hold", 32'h00000063, 1);
    @(negedge clk);
    flush = 1'b1;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_done_valid", 32'(out_valid[0]), 32'd0);

    // Reset pulse mid-BUSY.
    issue(0, AES_ESM, 1'b1, 2'd0, 32'h0, 32'h01020304);
    @(negedge clk) reset_n = 1'b0;
    #1;
    check("rst_busy_valid",  32'(out_valid[0]), 32'd0);
    check("rst_busy_ready",  32'(in_ready[0]),  32'd0);
    check("rst_busy_result", out_result[0],     32'h0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release_ready", 32'(in_ready[0]), 32'd1);
    watch_idle(0, 6, "rst_release_quiet");

    // Randomized requests against the reference model.
    for (int it = 0; it < 60; it++) begin
      r_k   = int'($urandom_range(0, 2));
      r_op  = 2'($urandom);
      r_col = 1'($urandom);
      r_bs  = 2'($urandom);
      r_a   = $urandom;
      r_b   = $urandom;
      r_exp = ref_req(r_op, r_col, r_bs, r_a, r_b);
      issue(r_k, r_op, r_col, r_bs, r_a, r_b);
      collect(r_k, "rand", r_exp, exp_lat(r_k, r_col));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
